// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU results and buffered load results into one registered regfile write per cycle.
// Define WB_SCOREBOARD_EN to build the pending-destination scoreboard on busy_o.
module reg_writeback #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic [4:0]  mem_rd_i,
    input  logic [31:0] mem_data_i,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_rd_i,
    output logic [31:0] busy_o,
    output logic        alu_hold_o,
    output logic        protocol_err_o,
    output logic [31:0] wr_data_o,
    output logic [4:0]  wr_port_o,
    output logic        ctrl_reg_we_o
);

    localparam int unsigned RD_W     = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned STARVE_W = 4;

    typedef struct packed {
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    wb_entry_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0]     rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0]     count, count_nxt;
    logic [STARVE_W-1:0]  starve_cnt, starve_nxt;
    logic                 hold_nxt, perr_nxt;
    logic                 we_nxt;
    logic [RD_W-1:0]      port_nxt;
    logic [DATA_W-1:0]    data_nxt;

    logic                 alu_sel, fifo_empty, fifo_full;
    logic                 push, pop, deferred;
    wb_entry_t            head;

    // Source arbitration: a real ALU write always wins, otherwise drain the load buffer.
    always_comb begin
        alu_sel    = alu_valid_i && (alu_rd_i != '0);
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_W'(FIFO_DEPTH));
        pop        = !alu_sel && !fifo_empty;
        deferred   = alu_sel && !fifo_empty;
        push       = mem_valid_i && mem_ready_o && (mem_rd_i != '0);
        head       = fifo_mem[rd_ptr];
    end

    assign mem_ready_o = rst_n && !fifo_full;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        starve_nxt = starve_cnt;
        hold_nxt   = alu_hold_o;
        perr_nxt   = protocol_err_o;
        we_nxt     = 1'b0;
        port_nxt   = wr_port_o;
        data_nxt   = wr_data_o;

        if (push) begin
            wr_ptr_nxt = wr_ptr + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase

        // Consecutive cycles the buffered head lost to the ALU.
        if (pop || fifo_empty) begin
            starve_nxt = '0;
        end else if (starve_cnt < STARVE_W'(STARVE_LIMIT)) begin
            starve_nxt = starve_cnt + STARVE_W'(1);
        end

        if (pop) begin
            hold_nxt = 1'b0;
        end else if (deferred && (starve_cnt >= STARVE_W'(STARVE_LIMIT - 1))) begin
            hold_nxt = 1'b1;
        end

        if (alu_sel && alu_hold_o) begin
            perr_nxt = 1'b1;
        end

        if (alu_sel) begin
            we_nxt   = 1'b1;
            port_nxt = alu_rd_i;
            data_nxt = alu_data_i;
        end else if (pop) begin
            we_nxt   = 1'b1;
            port_nxt = head.rd;
            data_nxt = head.data;
        end
    end

    // Load buffer storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr].rd   <= mem_rd_i;
            fifo_mem[wr_ptr].data <= mem_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            starve_cnt     <= '0;
            alu_hold_o     <= 1'b0;
            protocol_err_o <= 1'b0;
            ctrl_reg_we_o  <= 1'b0;
            wr_port_o      <= '0;
            wr_data_o      <= '0;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            count          <= count_nxt;
            starve_cnt     <= starve_nxt;
            alu_hold_o     <= hold_nxt;
            protocol_err_o <= perr_nxt;
            ctrl_reg_we_o  <= we_nxt;
            wr_port_o      <= port_nxt;
            wr_data_o      <= data_nxt;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy_nxt;

    // A new issue to the same register outranks the write retiring it.
    always_comb begin
        busy_nxt = busy_o;
        if (we_nxt) begin
            busy_nxt[port_nxt] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != '0)) begin
            busy_nxt[issue_rd_i] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_o <= '0;
        end else begin
            busy_o <= busy_nxt;
        end
    end
`else
    logic unused_issue;

    assign busy_o       = 32'h0;
    assign unused_issue = ^{issue_valid_i, issue_rd_i};
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: randomized and directed stimulus against a queue-based writeback model,
// with a scoreboard monitor comparing every cycle's outputs.
module tb_reg_writeback;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 4;
`ifdef WB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [4:0]  mem_rd_i;
    logic [31:0] mem_data_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic [31:0] busy_o;
    logic        alu_hold_o;
    logic        protocol_err_o;
    logic [31:0] wr_data_o;
    logic [4:0]  wr_port_o;
    logic        ctrl_reg_we_o;

    always #5 clk = ~clk;

    reg_writeback #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid_i    (alu_valid_i),
        .alu_rd_i       (alu_rd_i),
        .alu_data_i     (alu_data_i),
        .mem_valid_i    (mem_valid_i),
        .mem_ready_o    (mem_ready_o),
        .mem_rd_i       (mem_rd_i),
        .mem_data_i     (mem_data_i),
        .issue_valid_i  (issue_valid_i),
        .issue_rd_i     (issue_rd_i),
        .busy_o         (busy_o),
        .alu_hold_o     (alu_hold_o),
        .protocol_err_o (protocol_err_o),
        .wr_data_o      (wr_data_o),
        .wr_port_o      (wr_port_o),
        .ctrl_reg_we_o  (ctrl_reg_we_o)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    typedef struct {
        logic        we;
        logic [4:0]  port;
        logic [31:0] data;
        logic        hold;
        logic        perr;
        logic [31:0] busy;
        logic        ready;
    } exp_t;

    // Reference model state: queued loads, run of lost cycles, and last written port/data.
    entry_t      m_fifo[$];
    exp_t        exp_q[$];
    int          m_deferred;
    logic        m_hold;
    logic        m_perr;
    logic [31:0] m_busy;
    logic [4:0]  m_port;
    logic [31:0] m_data;

    bit          mon_en = 1'b0;
    int          n_chk  = 0;
    int          n_pass = 0;
    exp_t        mon_e;
    logic        dummy;
    logic        r_av;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL exp_queue: got empty queue expected a record at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("we",        32'(ctrl_reg_we_o),  32'(mon_e.we));
                chk("port",      32'(wr_port_o),      32'(mon_e.port));
                chk("data",      wr_data_o,           mon_e.data);
                chk("hold",      32'(alu_hold_o),     32'(mon_e.hold));
                chk("perr",      32'(protocol_err_o), 32'(mon_e.perr));
                chk("busy",      busy_o,              mon_e.busy);
                chk("mem_ready", 32'(mem_ready_o),    32'(mon_e.ready));
            end
        end
    end

    // Drive one cycle of inputs, advance the model, and queue the next cycle's expected outputs.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic iv, input logic [4:0] ird, output logic accepted);
        exp_t   e;
        entry_t h;
        bit     alu_wins, popped, was_empty;
        alu_valid_i   = av;
        alu_rd_i      = ard;
        alu_data_i    = ad;
        mem_valid_i   = mv;
        mem_rd_i      = mrd;
        mem_data_i    = md;
        issue_valid_i = iv;
        issue_rd_i    = ird;

        alu_wins  = av && (ard != 5'd0);
        accepted  = mv && (m_fifo.size() < DEPTH);
        was_empty = (m_fifo.size() == 0);
        popped    = 1'b0;
        e.we      = 1'b0;
        if (alu_wins) begin
            e.we = 1'b1; m_port = ard; m_data = ad;
        end else if (!was_empty) begin
            h = m_fifo.pop_front();
            e.we = 1'b1; m_port = h.rd; m_data = h.data; popped = 1'b1;
        end
        if (accepted && (mrd != 5'd0)) begin
            h.rd = mrd; h.data = md;
            m_fifo.push_back(h);
        end
        if (alu_wins && m_hold) m_perr = 1'b1;
        if (popped || was_empty) m_deferred = 0;
        else m_deferred++;
        if (popped) m_hold = 1'b0;
        else if (m_deferred >= int'(LIMIT)) m_hold = 1'b1;
        if (e.we) m_busy[m_port] = 1'b0;
        if (iv && (ird != 5'd0)) m_busy[ird] = 1'b1;

        e.port  = m_port;
        e.data  = m_data;
        e.hold  = m_hold;
        e.perr  = m_perr;
        e.busy  = SB_EN ? m_busy : 32'h0;
        e.ready = (m_fifo.size() < DEPTH);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, dummy);
    endtask

    task automatic do_reset();
        exp_t e;
        mon_en        = 1'b0;
        alu_valid_i   = 1'b0;
        mem_valid_i   = 1'b0;
        issue_valid_i = 1'b0;
        rst_n         = 1'b0;
        #1;
        chk("rst_we",    32'(ctrl_reg_we_o),  32'd0);
        chk("rst_port",  32'(wr_port_o),      32'd0);
        chk("rst_data",  wr_data_o,           32'd0);
        chk("rst_hold",  32'(alu_hold_o),     32'd0);
        chk("rst_perr",  32'(protocol_err_o), 32'd0);
        chk("rst_busy",  busy_o,              32'd0);
        chk("rst_ready", 32'(mem_ready_o),    32'd0);
        m_fifo.delete();
        exp_q.delete();
        m_deferred = 0; m_hold = 1'b0; m_perr = 1'b0;
        m_busy = 32'h0; m_port = 5'd0; m_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        e.we    = 1'b0; e.port = 5'd0; e.data = 32'h0; e.hold = 1'b0;
        e.perr  = 1'b0; e.busy = 32'h0; e.ready = 1'b1;
        exp_q.push_back(e);
        mon_en  = 1'b1;
    endtask

    // Offer n loads (rd = base+i), retrying each until the model says it was accepted.
    task automatic send_loads(input int n, input logic [4:0] base, input bit alu_busy, input bit issue);
        logic acc;
        int   tries;
        logic av;
        for (int i = 0; i < n; i++) begin
            acc   = 1'b0;
            tries = 0;
            while (!acc) begin
                av = alu_busy && !m_hold;
                step(av, 5'(20 + (tries % 8)), $urandom, 1'b1, base + 5'(i), $urandom,
                     issue, base + 5'(i), acc);
                tries++;
                if (!acc && tries > 64) begin
                    n_chk++;
                    $display("FAIL load_accept: got no accept after %0d cycles expected accept", tries);
                    break;
                end
            end
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        alu_valid_i   = 1'b0; alu_rd_i = 5'd0; alu_data_i = 32'd0;
        mem_valid_i   = 1'b0; mem_rd_i = 5'd0; mem_data_i = 32'd0;
        issue_valid_i = 1'b0; issue_rd_i = 5'd0;
        @(posedge clk);
        #1;
        do_reset();

        // ALU-only writes, including an ignored x0 result
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, dummy);
        step(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, dummy);
        idle(2);

        // Load fill without and with competing ALU traffic
        send_loads(5, 5'd1, 1'b0, 1'b0);
        idle(6);
        send_loads(5, 5'd1, 1'b1, 1'b0);
        idle(8);

        // Starvation: one queued load, ALU runs until held, then backs off
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99999999, 1'b0, 5'd0, dummy);
        for (int i = 0; i < 12 && !m_hold; i++)
            step(1'b1, 5'd3, $urandom, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, dummy);
        idle(3);

        // Loads with rd=0 complete the handshake but never write
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD0BAD0, 1'b0, 5'd0, dummy);
        idle(3);

        // Scoreboard: set, clear by load write, set-wins collision, x0 issue
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, dummy);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77777777, 1'b0, 5'd0, dummy);
        idle(2);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, dummy);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h70707070, 1'b0, 5'd0, dummy);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, dummy);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, dummy);
        idle(2);

        // Randomized traffic that honours the hold
        for (int i = 0; i < 300; i++) begin
            r_av = !m_hold && ($urandom_range(0, 99) < 60);
            step(r_av, 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom,
                 1'($urandom), 5'($urandom), dummy);
        end
        idle(8);

        // Hold violation: keep driving the ALU past the hold; error must stick
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA0A0A0A0, 1'b0, 5'd0, dummy);
        for (int i = 0; i < 8; i++)
            step(1'b1, 5'd4, $urandom, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, dummy);
        idle(5);

        // Reset mid-stream with queued loads and pending busy bits
        send_loads(3, 5'd11, 1'b1, 1'b1);
        do_reset();
        idle(6);

        for (int i = 0; i < 100; i++) begin
            r_av = !m_hold && ($urandom_range(0, 99) < 80);
            step(r_av, 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom,
                 1'($urandom), 5'($urandom), dummy);
        end
        idle(8);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
